ysyx_22050550_booth_mul: RTL and testbench

Parametrised radix-4 Booth multi-cycle integer multiplier for the EXU. It supports all RV64M signedness modes (uu/su/ss) and word mode (mulw), and retires 1 or 2 Booth digits per cycle. It has a full valid/ready handshake on both input and output, and a pipeline flush. It supersedes the fixed 64-bit multiplier, which had no output backpressure and no flush.

---
 rtl/ysyx_22050550_mul_pkg.sv | 17 +
 rtl/ysyx_22050550_booth_pp.sv | 19 +
 rtl/ysyx_22050550_booth_mul.sv | 113 +++++++++++
 tb/tb_ysyx_22050550_booth_mul.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_mul_pkg.sv
// ysyx_22050550_mul_pkg: shared types for the radix-4 Booth multiplier
package ysyx_22050550_mul_pkg;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;
    typedef enum logic [2:0] {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2} booth_e;
    function automatic booth_e booth_decode(input logic [2:0] w);
        case (w)
            3'b001, 3'b010: return BD_P1;
            3'b011:         return BD_P2;
            3'b100:         return BD_M2;
            3'b101, 3'b110: return BD_M1;
            default:        return BD_ZERO;
        endcase
    endfunction
endpackage

// File: rtl/ysyx_22050550_booth_pp.sv
// ysyx_22050550_booth_pp: selects one radix-4 Booth partial product from a 3-bit window
module ysyx_22050550_booth_pp
    import ysyx_22050550_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        win_i,
    input  logic [2*XLEN+1:0] a_i,
    output logic [2*XLEN+1:0] pp_o
);
    booth_e dig;
    always_comb begin
        dig = booth_decode(win_i);
        pp_o = dig == BD_P1 ? a_i :
               dig == BD_P2 ? a_i << 1 :
               dig == BD_M1 ? -a_i :
               dig == BD_M2 ? -(a_i << 1) : '0;
    end
endmodule

// File: rtl/ysyx_22050550_booth_mul.sv
// ysyx_22050550_booth_mul: multi-cycle radix-4 Booth multiplier with valid/ready and flush
module ysyx_22050550_booth_mul
    import ysyx_22050550_mul_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int WLEN             = 32,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            word,
    input  logic [1:0]      sign_mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);
    localparam int AW  = 2*XLEN+2;
    localparam int BW  = XLEN+3;
    localparam int DPC = DIGITS_PER_CYCLE;
    localparam int CW  = $clog2(XLEN+4);

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d, a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d, dig_q, dig_d;
    logic            word_q, word_d;
    logic            a_sgn, b_sgn, last;
    logic [AW-1:0]   a_ext;
    logic [BW-1:0]   b_ext;
    logic [2:0]      win [DPC];
    logic [AW-1:0]   pp  [DPC];
    logic [AW-1:0]   sum [DPC+1];

    assign a_sgn = sign_mode[1] & (word ? a[WLEN-1] : a[XLEN-1]);
    assign b_sgn = (sign_mode == MUL_SS) & (word ? b[WLEN-1] : b[XLEN-1]);
    assign a_ext = word ? {{(AW-WLEN){a_sgn}}, a[WLEN-1:0]} : {{(AW-XLEN){a_sgn}}, a};
    assign b_ext = word ? {{(BW-1-WLEN){b_sgn}}, b[WLEN-1:0], 1'b0} : {{(BW-1-XLEN){b_sgn}}, b, 1'b0};

    // Digits past the last one see a zero window, so a short final cycle adds nothing extra.
    assign sum[0] = acc_q;
    for (genvar j = 0; j < DPC; j++) begin : g_pp
        assign win[j] = (cnt_q + CW'(j) < dig_q) ? b_q[2*j+2 -: 3] : 3'b000;
        ysyx_22050550_booth_pp #(.XLEN(XLEN)) u_pp (
            .win_i(win[j]),
            .a_i  (a_q << (2*j)),
            .pp_o (pp[j])
        );
        assign sum[j+1] = sum[j] + pp[j];
    end
    assign last = cnt_q + CW'(DPC) >= dig_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        word_d  = word_q;
        if (flush) state_d = S_IDLE;
        else case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_BUSY;
                acc_d   = '0;
                a_d     = a_ext;
                b_d     = b_ext;
                cnt_d   = '0;
                dig_d   = word ? CW'(WLEN/2+1) : CW'(XLEN/2+1);
                word_d  = word;
            end
            S_BUSY: begin
                acc_d   = sum[DPC];
                a_d     = a_q << (2*DPC);
                b_d     = b_q >> (2*DPC);
                cnt_d   = cnt_q + CW'(DPC);
                state_d = last ? S_DONE : S_BUSY;
            end
            S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            word_q  <= word_d;
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign res_hi    = word_q ? '0 : acc_q[2*XLEN-1:XLEN];
    assign res_lo    = word_q ? {{(XLEN-WLEN){acc_q[WLEN-1]}}, acc_q[WLEN-1:0]} : acc_q[XLEN-1:0];
endmodule

// File: tb/tb_ysyx_22050550_booth_mul.sv
// tb_ysyx_22050550_booth_mul: two DUTs (1 and 2 digits/cycle) checked against a plain-arithmetic product model
module tb_ysyx_22050550_booth_mul;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, word = 1'b0, out_ready = 1'b0;
    logic [1:0]  sign_mode = 2'b00;
    logic [63:0] a = '0, b = '0;
    logic        ir1, ir2, ov1, ov2;
    logic [63:0] hi1, lo1, hi2, lo2;
    int          n_chk = 0, n_pass = 0;

    always #5 clock = ~clock;

    ysyx_22050550_booth_mul dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .flush(flush),
        .word(word), .sign_mode(sign_mode), .a(a), .b(b), .out_valid(ov1),
        .out_ready(out_ready), .res_hi(hi1), .res_lo(lo1)
    );
    ysyx_22050550_booth_mul #(.DIGITS_PER_CYCLE(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .flush(flush),
        .word(word), .sign_mode(sign_mode), .a(a), .b(b), .out_valid(ov2),
        .out_ready(out_ready), .res_hi(hi2), .res_lo(lo2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] ref_mul(input logic w, input logic [1:0] sm,
                                             input logic [63:0] x, input logic [63:0] y);
        logic [127:0] xe, ye, p;
        logic xs, ys;
        xs = sm[1];
        ys = sm == 2'b11;
        xe = w ? (xs ? {{96{x[31]}}, x[31:0]} : {96'b0, x[31:0]}) : (xs ? {{64{x[63]}}, x} : {64'b0, x});
        ye = w ? (ys ? {{96{y[31]}}, y[31:0]} : {96'b0, y[31:0]}) : (ys ? {{64{y[63]}}, y} : {64'b0, y});
        p = xe * ye;
        return w ? {64'b0, {32{p[31]}}, p[31:0]} : p;
    endfunction

    // Edges counted from the accept edge (inclusive) to the edge after which out_valid is high.
    function automatic int exp_lat(input logic w, input int dpc);
        int d;
        d = (w ? 32 : 64) / 2 + 1;
        return (d + dpc - 1) / dpc + 1;
    endfunction

    task automatic start(input logic w, input logic [1:0] sm, input logic [63:0] x, input logic [63:0] y);
        check("idle_ready", {ir1, ir2}, 2'b11);
        word = w; sign_mode = sm; a = x; b = y; in_valid = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        check("busy_ready", {ir1, ir2}, 2'b00);
    endtask

    task automatic wait_done(input logic [127:0] e, input int x1, input int x2);
        int t1, t2, n;
        t1 = 0; t2 = 0; n = 1;
        while ((t1 == 0 || t2 == 0) && n < 120) begin
            @(posedge clock); #1;
            n++;
            if (ov1 && t1 == 0) t1 = n;
            if (ov2 && t2 == 0) t2 = n;
        end
        check("lat_dpc1", t1, x1);
        check("lat_dpc2", t2, x2);
        check("res_dpc1", {hi1, lo1}, e);
        check("res_dpc2", {hi2, lo2}, e);
    endtask

    task automatic release_out(input logic [127:0] e, input int stall);
        repeat (stall) begin
            @(posedge clock); #1;
            check("hold_valid", {ov1, ov2}, 2'b11);
            check("hold_ready", {ir1, ir2}, 2'b00);
            check("hold_res", {hi1, lo1}, e);
        end
        out_ready = 1'b1;
        @(posedge clock); #1 out_ready = 1'b0;
        check("hs_ready", {ir1, ir2}, 2'b11);
        check("hs_valid", {ov1, ov2}, 2'b00);
    endtask

    task automatic run(input logic w, input logic [1:0] sm, input logic [63:0] x, input logic [63:0] y,
                       input int stall);
        logic [127:0] e;
        e = ref_mul(w, sm, x, y);
        start(w, sm, x, y);
        wait_done(e, exp_lat(w, 1), exp_lat(w, 2));
        release_out(e, stall);
    endtask

    task automatic abort_busy(input logic use_reset);
        logic seen;
        start(1'b0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
        repeat (9) @(posedge clock);
        #1;
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        @(posedge clock); #1 begin reset = 1'b0; flush = 1'b0; end
        check("abort_ready", {ir1, ir2}, 2'b11);
        check("abort_valid", {ov1, ov2}, 2'b00);
        if (use_reset) check("reset_res", {hi1, lo1, hi2, lo2}, '0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1 seen |= ov1 | ov2;
        end
        check("abort_no_result", seen, 1'b0);
        run(1'b0, 2'b11, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_ready", {ir1, ir2}, 2'b11);
        check("rst_valid", {ov1, ov2}, 2'b00);
        check("rst_res1", {hi1, lo1}, '0);
        check("rst_res2", {hi2, lo2}, '0);

        run(1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5);
        run(1'b0, 2'b00, '1, '1, 0);
        run(1'b0, 2'b10, '1, '1, 1);
        run(1'b1, 2'b11, 64'h0000_0000_4000_0000, 64'd2, 0);
        run(1'b0, 2'b01, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_0000_0003, 0);

        in_valid = 1'b1; flush = 1'b1;
        @(posedge clock); #1 begin in_valid = 1'b0; flush = 1'b0; end
        check("flush_no_accept", {ir1, ir2}, 2'b11);

        start(1'b1, 2'b10, 64'hDEAD_BEEF_8765_4321, 64'h0BAD_F00D_FFFF_FFF7);
        wait_done(ref_mul(1'b1, 2'b10, 64'hDEAD_BEEF_8765_4321, 64'h0BAD_F00D_FFFF_FFF7),
                  exp_lat(1'b1, 1), exp_lat(1'b1, 2));
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1 begin flush = 1'b0; out_ready = 1'b0; end
        check("done_flush_ready", {ir1, ir2}, 2'b11);
        check("done_flush_valid", {ov1, ov2}, 2'b00);

        abort_busy(1'b0);
        abort_busy(1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [63:0] x, y;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 5 == 1) x = {x[0], 63'b0};
            if (i % 7 == 2) y = {64{y[3]}};
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), x, y, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
